rv_dp_ram_ctrl: RTL and testbench

Multi-requester access controller for a dual-port RAM in the GPU core's local-memory path. Accepts read and write requests from `NUM_REQS` clients over valid/ready handshakes, picks one write and one read winner per cycle with independent round-robin arbiters, and drives an internal `RV_dp_ram` instance configured with a registered read port. Returns read data one cycle after acceptance, tagged with the requester index. Same-cycle read/write collisions on one address are bypassed so the read sees the new bytes.

---
 rtl/rv_dp_ram_ctrl_pkg.sv | 29 ++
 rtl/rv_dp_ram_ctrl_if.sv | 32 +++
 rtl/RV_dp_ram.sv | 49 ++++
 rtl/rv_rr_arbiter.sv | 44 ++++
 rtl/rv_dp_ram_ctrl.sv | 128 ++++++++++++
 tb/tb_rv_dp_ram_ctrl.sv | 252 +++++++++++++++++++++++++
 6 files changed

// File: rtl/rv_dp_ram_ctrl_pkg.sv
// Shared helpers for the dual-port RAM access controller:
// requester-index width and byte-lane merge used by the collision bypass.
package rv_dp_ram_ctrl_pkg;

   localparam int MAX_DATAW   = 256;
   localparam int MAX_BYTEENW = 32;

   function automatic int calc_reqw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Lanes whose mask bit is set take new_word, the rest keep old_word.
   function automatic logic [MAX_DATAW-1:0] merge_bytes(
      input logic [MAX_BYTEENW-1:0] mask,
      input logic [MAX_DATAW-1:0]   new_word,
      input logic [MAX_DATAW-1:0]   old_word,
      input int                     byte_w
   );
      logic [MAX_DATAW-1:0] unit;
      logic [MAX_DATAW-1:0] bit_mask;
      unit     = (MAX_DATAW'(1) << byte_w) - MAX_DATAW'(1);
      bit_mask = '0;
      for (int k = 0; k < MAX_BYTEENW; k++) begin
         if (mask[k]) bit_mask = bit_mask | (unit << (k * byte_w));
      end
      return (new_word & bit_mask) | (old_word & ~bit_mask);
   endfunction

endpackage

// File: rtl/rv_dp_ram_ctrl_if.sv
// Request/response bundle between requesters and the RAM controller.
interface rv_dp_ram_ctrl_if
   import rv_dp_ram_ctrl_pkg::*;
#(
   parameter int NUM_REQS = 4,
   parameter int DATAW    = 32,
   parameter int BYTEENW  = 4,
   parameter int ADDRW    = 8,
   parameter int REQW     = calc_reqw(NUM_REQS)
);

   logic [NUM_REQS-1:0]         req_valid;
   logic [NUM_REQS-1:0]         req_rw;
   logic [NUM_REQS*ADDRW-1:0]   req_addr;
   logic [NUM_REQS*DATAW-1:0]   req_data;
   logic [NUM_REQS*BYTEENW-1:0] req_byteen;
   logic [NUM_REQS-1:0]         req_ready;
   logic                        rsp_valid;
   logic [REQW-1:0]             rsp_idx;
   logic [DATAW-1:0]            rsp_data;

   modport master (
      output req_valid, req_rw, req_addr, req_data, req_byteen,
      input  req_ready, rsp_valid, rsp_idx, rsp_data
   );

   modport slave (
      input  req_valid, req_rw, req_addr, req_data, req_byteen,
      output req_ready, rsp_valid, rsp_idx, rsp_data
   );

endinterface

// File: rtl/RV_dp_ram.sv
// Simple dual-port RAM: byte-enabled write port, read port optionally
// registered. Reads return the pre-write contents on a same-cycle collision.
module RV_dp_ram #(
   parameter int DATAW   = 32,
   parameter int SIZE    = 256,
   parameter int BYTEENW = 4,
   parameter int OUT_REG = 1,
   parameter int ADDRW   = $clog2(SIZE)
) (
   input  logic               clk,
   input  logic [BYTEENW-1:0] wren,
   input  logic [ADDRW-1:0]   waddr,
   input  logic [DATAW-1:0]   wdata,
   input  logic               rden,
   input  logic [ADDRW-1:0]   raddr,
   output logic [DATAW-1:0]   rdata
);

   localparam int BYTEW = DATAW / BYTEENW;

   logic [DATAW-1:0] mem_q [SIZE];

   always_ff @(posedge clk) begin
      for (int k = 0; k < BYTEENW; k++) begin
         if (wren[k]) mem_q[waddr][k*BYTEW +: BYTEW] <= wdata[k*BYTEW +: BYTEW];
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATAW-1:0] rdata_q;
         logic [DATAW-1:0] rdata_d;

         always_comb begin
            rdata_d = rdata_q;
            if (rden) rdata_d = mem_q[raddr];
         end

         always_ff @(posedge clk) begin
            rdata_q <= rdata_d;
         end

         assign rdata = rdata_q;
      end else begin : g_out_comb
         assign rdata = mem_q[raddr];
      end
   endgenerate

endmodule

// File: rtl/rv_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the priority
// pointer (wrapping), then moves the pointer just past the winner.
module rv_rr_arbiter
   import rv_dp_ram_ctrl_pkg::*;
#(
   parameter int NUM_REQS = 4,
   parameter int REQW     = calc_reqw(NUM_REQS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_REQS-1:0] requests,
   input  logic                grant_en,
   output logic [NUM_REQS-1:0] grant,
   output logic [REQW-1:0]     grant_idx,
   output logic                grant_valid
);

   logic [REQW-1:0] ptr_q;
   logic [REQW-1:0] ptr_d;
   logic [REQW-1:0] cand;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      ptr_d       = ptr_q;
      for (int off = 0; off < NUM_REQS; off++) begin
         cand = REQW'((int'(ptr_q) + off) % NUM_REQS);
         if (grant_en && !grant_valid && requests[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
      if (grant_valid) ptr_d = REQW'((int'(grant_idx) + 1) % NUM_REQS);
   end

   always_ff @(posedge clk) begin
      if (!reset) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/rv_dp_ram_ctrl.sv
// Multi-requester controller for a dual-port RAM: independent round-robin
// write and read arbitration, 1-cycle read latency, write-first bypass.
module rv_dp_ram_ctrl
   import rv_dp_ram_ctrl_pkg::*;
#(
   parameter int NUM_REQS = 4,
   parameter int DATAW    = 32,
   parameter int SIZE     = 256,
   parameter int BYTEENW  = 4,
   parameter int ADDRW    = $clog2(SIZE),
   parameter int REQW     = calc_reqw(NUM_REQS)
) (
   input  logic             clk,
   input  logic             reset,
   rv_dp_ram_ctrl_if.slave  bus
);

   logic [NUM_REQS-1:0] wr_req;
   logic [NUM_REQS-1:0] rd_req;
   logic [NUM_REQS-1:0] wr_grant;
   logic [NUM_REQS-1:0] rd_grant;
   logic [REQW-1:0]     wr_idx;
   logic [REQW-1:0]     rd_idx;
   logic                wr_gv;
   logic                rd_gv;

   logic [BYTEENW-1:0]  ram_wren;
   logic [ADDRW-1:0]    ram_waddr;
   logic [DATAW-1:0]    ram_wdata;
   logic [ADDRW-1:0]    ram_raddr;
   logic [DATAW-1:0]    ram_rdata;
   logic                collision;

   logic                rsp_valid_q, rsp_valid_d;
   logic [REQW-1:0]     rsp_idx_q,   rsp_idx_d;
   logic [BYTEENW-1:0]  byp_mask_q,  byp_mask_d;
   logic [DATAW-1:0]    byp_data_q,  byp_data_d;

   assign wr_req = bus.req_valid &  bus.req_rw;
   assign rd_req = bus.req_valid & ~bus.req_rw;

   // Grants are suppressed while reset is held low.
   rv_rr_arbiter #(.NUM_REQS(NUM_REQS), .REQW(REQW)) u_wr_arb (
      .clk         (clk),
      .reset       (reset),
      .requests    (wr_req),
      .grant_en    (reset),
      .grant       (wr_grant),
      .grant_idx   (wr_idx),
      .grant_valid (wr_gv)
   );

   rv_rr_arbiter #(.NUM_REQS(NUM_REQS), .REQW(REQW)) u_rd_arb (
      .clk         (clk),
      .reset       (reset),
      .requests    (rd_req),
      .grant_en    (reset),
      .grant       (rd_grant),
      .grant_idx   (rd_idx),
      .grant_valid (rd_gv)
   );

   assign bus.req_ready = wr_grant | rd_grant;

   always_comb begin
      ram_wren  = '0;
      ram_waddr = '0;
      ram_wdata = '0;
      ram_raddr = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (wr_gv && wr_idx == REQW'(i)) begin
            ram_waddr = bus.req_addr[i*ADDRW +: ADDRW];
            ram_wdata = bus.req_data[i*DATAW +: DATAW];
            ram_wren  = (BYTEENW == 1) ? '1 : bus.req_byteen[i*BYTEENW +: BYTEENW];
         end
         if (rd_gv && rd_idx == REQW'(i)) begin
            ram_raddr = bus.req_addr[i*ADDRW +: ADDRW];
         end
      end
   end

   assign collision = wr_gv && rd_gv && (ram_waddr == ram_raddr);

   always_comb begin
      rsp_valid_d = rd_gv;
      rsp_idx_d   = rd_gv ? rd_idx : rsp_idx_q;
      byp_mask_d  = collision ? ram_wren : '0;
      byp_data_d  = ram_wdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rsp_valid_q <= 1'b0;
         rsp_idx_q   <= '0;
         byp_mask_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_idx_q   <= rsp_idx_d;
         byp_mask_q  <= byp_mask_d;
      end
      byp_data_q <= byp_data_d;
   end

   RV_dp_ram #(
      .DATAW   (DATAW),
      .SIZE    (SIZE),
      .BYTEENW (BYTEENW),
      .OUT_REG (1),
      .ADDRW   (ADDRW)
   ) u_ram (
      .clk   (clk),
      .wren  (ram_wren),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .rden  (rd_gv),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // RAM returns pre-write data; overlay the bytes written alongside the read.
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_idx   = rsp_idx_q;
   assign bus.rsp_data  = DATAW'(merge_bytes(MAX_BYTEENW'(byp_mask_q),
                                             MAX_DATAW'(byp_data_q),
                                             MAX_DATAW'(ram_rdata),
                                             DATAW / BYTEENW));

endmodule

// File: tb/tb_rv_dp_ram_ctrl.sv
// Randomized scoreboard bench for rv_dp_ram_ctrl against a word-array model.
module tb_rv_dp_ram_ctrl;
   import rv_dp_ram_ctrl_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int SZ = 256;
   localparam int BE = 4;
   localparam int AW = 8;
   localparam int RW = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rv_dp_ram_ctrl_if #(.NUM_REQS(N), .DATAW(DW), .BYTEENW(BE), .ADDRW(AW), .REQW(RW)) bus ();
   rv_dp_ram_ctrl_if #(.NUM_REQS(1), .DATAW(16), .BYTEENW(1), .ADDRW(4), .REQW(1)) bus2 ();

   rv_dp_ram_ctrl #(.NUM_REQS(N), .DATAW(DW), .SIZE(SZ), .BYTEENW(BE), .ADDRW(AW), .REQW(RW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   rv_dp_ram_ctrl #(.NUM_REQS(1), .DATAW(16), .SIZE(16), .BYTEENW(1), .ADDRW(4), .REQW(1)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   typedef struct {
      int unsigned due;
      int          idx;
      logic [DW-1:0] data;
      bit          chk;
   } exp_t;

   int          checks   = 0;
   int          failures = 0;
   int unsigned edge_cnt = 0;
   bit          mon_en   = 1'b0;
   bit          last_rst = 1'b1;
   exp_t        q[$];
   exp_t        mon_e;

   logic [DW-1:0] mem_m [SZ];
   bit            known [SZ];
   int            wptr = 0;
   int            rptr = 0;

   logic [N-1:0]  s_v;
   logic [N-1:0]  s_rw;
   logic [AW-1:0] s_addr [N];
   logic [DW-1:0] s_data [N];
   logic [BE-1:0] s_be   [N];

   always @(posedge clk) edge_cnt++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic clr();
      s_v  = '0;
      s_rw = '0;
      for (int i = 0; i < N; i++) begin
         s_addr[i] = '0;
         s_data[i] = '0;
         s_be[i]   = '0;
      end
   endtask

   // One clock: drive the stored request set, check ready, advance the model.
   task automatic step(input bit rst_n);
      int wg, rg, a;
      logic [N-1:0] exp_ready;
      @(posedge clk);
      #1;
      if (!last_rst) begin
         check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
         check("rst_rsp_idx", 64'(bus.rsp_idx), 64'd0);
      end
      reset = rst_n;
      bus.req_valid = s_v;
      bus.req_rw    = s_rw;
      for (int i = 0; i < N; i++) begin
         bus.req_addr[i*AW +: AW]   = s_addr[i];
         bus.req_data[i*DW +: DW]   = s_data[i];
         bus.req_byteen[i*BE +: BE] = s_be[i];
      end
      #1;
      wg = -1;
      rg = -1;
      exp_ready = '0;
      if (rst_n) begin
         for (int off = 0; off < N; off++) begin
            int c;
            c = (wptr + off) % N;
            if (wg < 0 && s_v[c] && s_rw[c]) wg = c;
            c = (rptr + off) % N;
            if (rg < 0 && s_v[c] && !s_rw[c]) rg = c;
         end
      end
      if (wg >= 0) exp_ready[wg] = 1'b1;
      if (rg >= 0) exp_ready[rg] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      if (!rst_n) begin
         wptr = 0;
         rptr = 0;
      end else begin
         if (wg >= 0) begin
            a = int'(s_addr[wg]);
            for (int k = 0; k < BE; k++)
               if (s_be[wg][k]) mem_m[a][k*8 +: 8] = s_data[wg][k*8 +: 8];
            if (s_be[wg] == '1) known[a] = 1'b1;
            wptr = (wg + 1) % N;
         end
         if (rg >= 0) begin
            a = int'(s_addr[rg]);
            q.push_back('{due: edge_cnt + 1, idx: rg, data: mem_m[a], chk: known[a]});
            rptr = (rg + 1) % N;
         end
      end
      last_rst = rst_n;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rsp_unexpected: got rsp_valid=1 idx=%0d expected no response", bus.rsp_idx);
            end else begin
               mon_e = q.pop_front();
               check("rsp_cycle", 64'(edge_cnt), 64'(mon_e.due));
               check("rsp_idx", 64'(bus.rsp_idx), 64'(mon_e.idx));
               if (mon_e.chk) check("rsp_data", 64'(bus.rsp_data), 64'(mon_e.data));
            end
         end else if (q.size() > 0 && q[0].due <= edge_cnt) begin
            checks++;
            failures++;
            $display("FAIL rsp_missing: got rsp_valid=%b expected response idx=%0d", bus.rsp_valid, q[0].idx);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      bus.req_valid = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_data = '0; bus.req_byteen = '0;
      bus2.req_valid = '0; bus2.req_rw = '0; bus2.req_addr = '0; bus2.req_data = '0; bus2.req_byteen = '0;
      for (int a = 0; a < SZ; a++) known[a] = 1'b0;
      clr();
      step(0);
      step(0);
      mon_en = 1'b1;

      // write then read back through requester 0
      clr(); s_v[0] = 1; s_rw[0] = 1; s_addr[0] = 8'd5; s_data[0] = 32'hDEADBEEF; s_be[0] = 4'hF;
      step(1);
      clr(); s_v[0] = 1; s_addr[0] = 8'd5;
      step(1);

      // known contents for the random address window
      for (int a = 0; a < 16; a++) begin
         int r;
         r = $urandom_range(0, N-1);
         clr(); s_v[r] = 1; s_rw[r] = 1; s_addr[r] = AW'(a); s_be[r] = 4'hF;
         s_data[r] = (a == 9) ? 32'h11223344 : $urandom;
         step(1);
      end

      // all requesters reading for 8 cycles
      for (int c = 0; c < 8; c++) begin
         clr();
         for (int i = 0; i < N; i++) begin
            s_v[i] = 1; s_addr[i] = AW'($urandom_range(0, 15));
         end
         step(1);
      end

      // same-cycle partial write and read of address 9
      clr();
      s_v[1] = 1; s_rw[1] = 1; s_addr[1] = 8'd9; s_data[1] = 32'hAABBCCDD; s_be[1] = 4'h5;
      s_v[2] = 1; s_addr[2] = 8'd9;
      step(1);

      // continuous writer 3 and reader 0
      for (int c = 0; c < 12; c++) begin
         clr();
         s_v[3] = 1; s_rw[3] = 1; s_addr[3] = AW'($urandom_range(0, 15));
         s_data[3] = $urandom; s_be[3] = BE'($urandom);
         s_v[0] = 1; s_addr[0] = AW'($urandom_range(0, 15));
         step(1);
      end

      // reset with a read in flight, then pointer restart
      clr(); s_v[1] = 1; s_addr[1] = 8'd3;
      step(1);
      clr();
      step(0);
      clr(); s_v[2] = 1; s_addr[2] = 8'd4; s_v[0] = 1; s_addr[0] = 8'd6;
      step(1);

      // random traffic with occasional resets
      for (int c = 0; c < 400; c++) begin
         s_v  = N'($urandom);
         s_rw = N'($urandom);
         for (int i = 0; i < N; i++) begin
            s_addr[i] = AW'($urandom_range(0, 15));
            s_data[i] = $urandom;
            s_be[i]   = BE'($urandom);
         end
         step(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
      end

      clr();
      for (int c = 0; c < 3; c++) step(1);
      check("drain_empty", 64'(q.size()), 64'd0);

      // whole-word build, single requester
      @(posedge clk); #1;
      bus2.req_valid = 1'b1; bus2.req_rw = 1'b1; bus2.req_addr = 4'd0;
      bus2.req_data = 16'hBEEF; bus2.req_byteen = 1'b0;
      #1 check("w16_wr_ready", 64'(bus2.req_ready), 64'd1);
      @(posedge clk); #1;
      bus2.req_rw = 1'b0;
      #1 check("w16_rd_ready", 64'(bus2.req_ready), 64'd1);
      @(posedge clk); #1;
      bus2.req_valid = 1'b0;
      check("w16_rsp_valid", 64'(bus2.rsp_valid), 64'd1);
      check("w16_rsp_idx", 64'(bus2.rsp_idx), 64'd0);
      check("w16_rsp_data", 64'(bus2.rsp_data), 64'hBEEF);
      @(posedge clk); #1;
      check("w16_rsp_idle", 64'(bus2.rsp_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
